// File: rtl/dong_ho_v2_if.sv
// Time-load handshake between a setting controller (master) and the clock core (slave).
// The controller drives a BCD time and a one-cycle request; the core answers with ack or err.
interface dong_ho_v2_if;
    logic       set_vld;
    logic [7:0] set_hh;
    logic [7:0] set_mm;
    logic [7:0] set_ss;
    logic       set_ack;
    logic       set_err;

    modport master (
        output set_vld, set_hh, set_mm, set_ss,
        input  set_ack, set_err
    );

    modport slave (
        input  set_vld, set_hh, set_mm, set_ss,
        output set_ack, set_err
    );
endinterface

// File: rtl/dong_ho_v2.sv
// BCD real-time clock with prescaler, 12/24 h display and validated time load.
// Optional minute alarm is enabled by defining DONG_HO_ALARM_EN.
module dong_ho_v2 #(
    parameter int CLK_HZ = 50000000,
    parameter int DIV_W  = 26
) (
    input  logic        clki,
    input  logic        rs,
    input  logic        run,
    input  logic        mode12,
    dong_ho_v2_if.slave set_bus,
    output logic [3:0]  led1,
    output logic [3:0]  led2,
    output logic [3:0]  led3,
    output logic [3:0]  led4,
    output logic [3:0]  led5,
    output logic [3:0]  led6,
    output logic        pm,
    output logic        tick1hz,
    output logic        day_wrap,
    input  logic        alm_on,
    input  logic [7:0]  alm_hh,
    input  logic [7:0]  alm_mm,
    output logic        alarm
);

    localparam logic [DIV_W-1:0] TERM = DIV_W'(CLK_HZ - 1);

    logic [DIV_W-1:0] presc, presc_nxt;
    logic [3:0] sec_u, sec_t, min_u, min_t, hr_u, hr_t;
    logic [3:0] n_sec_u, n_sec_t, n_min_u, n_min_t, n_hr_u, n_hr_t;
    logic       tick_now, set_valid, load_ok, tick_adv, at_end;

    // Display hour as {tens,units}; in 12 h mode midnight shows 12 and afternoon folds down.
    function automatic logic [7:0] fmt_hour(input logic [3:0] t, input logic [3:0] u,
                                            input logic m12);
        logic [4:0] h;
        logic [4:0] h12;
        h   = ({1'b0, t} * 5'd10) + {1'b0, u};
        h12 = h - 5'd12;
        if (!m12 || (h != 5'd0 && h <= 5'd12))
            return {t, u};
        else if (h == 5'd0)
            return 8'h12;
        else if (h12 >= 5'd10)
            return {4'd1, 4'(h12 - 5'd10)};
        else
            return {4'd0, h12[3:0]};
    endfunction

    function automatic logic is_pm(input logic [3:0] t, input logic [3:0] u);
        return (t == 4'd2) || (t == 4'd1 && u >= 4'd2);
    endfunction

    assign tick_now  = run && (presc == TERM);
    assign set_valid = (set_bus.set_ss[3:0] <= 4'd9) && (set_bus.set_ss[7:4] <= 4'd5) &&
                       (set_bus.set_mm[3:0] <= 4'd9) && (set_bus.set_mm[7:4] <= 4'd5) &&
                       (set_bus.set_hh[3:0] <= 4'd9) && (set_bus.set_hh <= 8'h23);
    assign load_ok   = set_bus.set_vld && set_valid;
    assign tick_adv  = tick_now && !load_ok;
    assign at_end    = {hr_t, hr_u, min_t, min_u, sec_t, sec_u} == 24'h235959;

    // An accepted load restarts the second; otherwise the count only moves while running.
    always_comb begin
        presc_nxt = presc;
        if (load_ok)
            presc_nxt = '0;
        else if (run)
            presc_nxt = tick_now ? '0 : presc + DIV_W'(1);
    end

    always_comb begin
        {n_hr_t, n_hr_u, n_min_t, n_min_u, n_sec_t, n_sec_u} =
            {hr_t, hr_u, min_t, min_u, sec_t, sec_u};
        if (load_ok) begin
            {n_hr_t, n_hr_u}   = set_bus.set_hh;
            {n_min_t, n_min_u} = set_bus.set_mm;
            {n_sec_t, n_sec_u} = set_bus.set_ss;
        end else if (tick_adv) begin
            if (sec_u != 4'd9) n_sec_u = sec_u + 4'd1;
            else begin
                n_sec_u = 4'd0;
                if (sec_t != 4'd5) n_sec_t = sec_t + 4'd1;
                else begin
                    n_sec_t = 4'd0;
                    if (min_u != 4'd9) n_min_u = min_u + 4'd1;
                    else begin
                        n_min_u = 4'd0;
                        if (min_t != 4'd5) n_min_t = min_t + 4'd1;
                        else begin
                            n_min_t = 4'd0;
                            if (hr_t == 4'd2 && hr_u == 4'd3) begin
                                n_hr_t = 4'd0;
                                n_hr_u = 4'd0;
                            end else if (hr_u == 4'd9) begin
                                n_hr_u = 4'd0;
                                n_hr_t = hr_t + 4'd1;
                            end else begin
                                n_hr_u = hr_u + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Display registers follow the next time so tick1hz lines up with the new digits.
    always_ff @(posedge clki) begin
        if (rs) begin
            presc            <= '0;
            {hr_t, hr_u, min_t, min_u, sec_t, sec_u} <= '0;
            set_bus.set_ack  <= 1'b0;
            set_bus.set_err  <= 1'b0;
            tick1hz          <= 1'b0;
            day_wrap         <= 1'b0;
            pm               <= 1'b0;
            {led6, led5}     <= fmt_hour(4'd0, 4'd0, mode12);
            {led4, led3, led2, led1} <= '0;
        end else begin
            presc            <= presc_nxt;
            {hr_t, hr_u, min_t, min_u, sec_t, sec_u} <=
                {n_hr_t, n_hr_u, n_min_t, n_min_u, n_sec_t, n_sec_u};
            set_bus.set_ack  <= load_ok;
            set_bus.set_err  <= set_bus.set_vld && !set_valid;
            tick1hz          <= tick_adv;
            day_wrap         <= tick_adv && at_end;
            pm               <= is_pm(n_hr_t, n_hr_u);
            {led6, led5}     <= fmt_hour(n_hr_t, n_hr_u, mode12);
            {led4, led3, led2, led1} <= {n_min_t, n_min_u, n_sec_t, n_sec_u};
        end
    end

`ifdef DONG_HO_ALARM_EN
    always_ff @(posedge clki) begin
        if (rs)
            alarm <= 1'b0;
        else
            alarm <= alm_on && ({n_hr_t, n_hr_u, n_min_t, n_min_u} == {alm_hh, alm_mm});
    end
`else
    logic unused_alarm_inputs;
    assign unused_alarm_inputs = ^{alm_on, alm_hh, alm_mm};
    assign alarm = 1'b0;
`endif

endmodule

// File: doc/dong_ho_v2.md
DONG_HO_V2 -- requirements
Module: dong_ho_v2

Interface
REQ-001 Parameter: CLK_HZ, 50000000, clki frequency in Hz; prescaler terminal count is CLK_HZ-1; legal range 2..2^26.
REQ-002 Parameter: DIV_W, 26, prescaler width; SHALL satisfy 2^DIV_W >= CLK_HZ.
REQ-003 Port: clki  input  1  sole clock; all state changes on rising edge.
REQ-004 Port: rs  input  1  reset, synchronous, active-high.
REQ-005 Port: run  input  1  1 = timekeeping advances; 0 = prescaler and time frozen.
REQ-006 Port: mode12  input  1  display format: 0 = 24 h, 1 = 12 h.
REQ-007 Port: set_vld  input  1  one-cycle request to load set_hh/set_mm/set_ss.
REQ-008 Port: set_hh, set_mm, set_ss  input  8 each  packed BCD load value {tens,units}; hours always in 24 h form.
REQ-009 Port: set_ack / set_err  output  1 each  one-cycle pulses: load accepted / load rejected.
REQ-010 Port: led1..led6  output  4 each  BCD digits: led1 sec units, led2 sec tens, led3 min units, led4 min tens, led5 hour units, led6 hour tens.
REQ-011 Port: pm  output  1  1 when internal hour >= 12 (valid in both modes).
REQ-012 Port: tick1hz / day_wrap  output  1 each  one-cycle pulses: second advanced / 23:59:59 -> 00:00:00.
REQ-013 Port: alm_on  input  1;  alm_hh, alm_mm  input  8 each (BCD, 24 h);  alarm  output  1.

Function
REQ-014 Prescaler SHALL count 0..CLK_HZ-1 while run=1; at CLK_HZ-1 it SHALL return to 0 and generate one second-tick.
REQ-015 On a second-tick, time SHALL advance by one second in the same clock edge; tick1hz SHALL be high in the cycle the new time is first visible on led1..led6.
REQ-016 Seconds and minutes SHALL count BCD 00..59; hours 00..23; units digit 9 -> 0 carries to tens; 59 -> 00 carries to next field.
REQ-017 At 23:59:59 a tick SHALL yield 00:00:00 and assert day_wrap for exactly that cycle.
REQ-018 mode12=0: led6/led5 SHALL show hour 00..23. mode12=1: hour 0 SHALL show 12, 1..12 SHALL show 01..12, 13..23 SHALL show 01..11; minutes/seconds unaffected.
REQ-019 Outputs led1..led6 and pm SHALL be registered; a mode12 change SHALL appear on the outputs one cycle later without altering internal time.
REQ-020 Load accepted only if every digit <= 9, set_ss <= 0x59, set_mm <= 0x59, set_hh <= 0x23; accepted load SHALL replace time and clear prescaler at the next edge, with set_ack high in that cycle.
REQ-021 Invalid load SHALL leave time and prescaler unchanged and pulse set_err for one cycle.
REQ-022 set_vld coinciding with a second-tick: the load SHALL win; no tick1hz, no day_wrap, no increment that cycle.
REQ-023 set_vld SHALL be honoured regardless of run.
REQ-024 run=0 SHALL freeze the prescaler value; run returning to 1 SHALL resume from the frozen count.

Reset
REQ-025 rs=1 at an edge SHALL set prescaler 0, time 00:00:00, set_ack, set_err, tick1hz, day_wrap, alarm and pm to 0; led1..led6 to 0 except led6/led5 = 1/2 if mode12=1.
REQ-026 rs SHALL override run, set_vld and any pending tick in the same cycle; an in-flight load is discarded.

Configuration
REQ-027 Macro DONG_HO_ALARM_EN defined: alarm SHALL be registered high while alm_on=1 and internal hh:mm equals alm_hh:alm_mm (whole matching minute), low otherwise.
REQ-028 Macro DONG_HO_ALARM_EN undefined: alarm SHALL be constant 0, alm_on/alm_hh/alm_mm ignored; port list unchanged.

Verification (CLK_HZ=4)
REQ-029 rs 1 cycle, run=1, mode12=0 -> tick1hz every 4th cycle; after 4 ticks led2..led1 = 0,4.
REQ-030 Load 23:59:58 -> set_ack; 2 ticks later leds 00:00:00, day_wrap one cycle, pm 1 -> 0.
REQ-031 Load hh=0x24 -> set_err one cycle, time unchanged; load ss=0x5A -> set_err.
REQ-032 Time 00:30:00 then 13:05:00, mode12=1 -> leds 12:30:00 pm=0, then 01:05:00 pm=1.
REQ-033 set_vld on tick cycle with set 10:00:00 -> time 10:00:00, no tick1hz; run=0 for 10 cycles -> time static.
REQ-034 DONG_HO_ALARM_EN, alm 07:00, alm_on=1, load 06:59:59 -> one tick later alarm=1; alm_on=0 -> alarm=0 next cycle.
